// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default bit period used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 217;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs; the reset
// value matches the idle level of the signal being synchronized.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled RX pin, LSB-first byte recovery and a
// one-entry valid/ready output buffer with framing/overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           rxs_prev_q;
  logic           rxs_s;
  logic           fall_s;
  logic           commit_s;
  logic           ferr_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxs_s)
  );

  assign fall_s = rxs_prev_q & ~rxs_s;

  // State, timing and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rxs_prev_q  <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rxs_prev_q  <= rxs_s;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame sequencing: the bit timer only ever wraps through an explicit clear.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    commit_s  = 1'b0;
    ferr_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          timer_d = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          if (rxs_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d          = '0;
          shift_d[bit_idx_q] = rxs_s;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rxs_s) begin
            commit_s = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      BREAK: begin
        // A held-low line must return high before a new start can be seen.
        if (rxs_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // One-entry output buffer: a commit into a full, unconsumed buffer is dropped.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = ferr_s;
    overrun_d   = 1'b0;
    if (commit_s) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// with a scoreboard queue of expected bytes and error-pulse counters.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         model_full = 1'b0;
  int         exp_ferr = 0;
  int         obs_ferr = 0;
  int         exp_ovr = 0;
  int         obs_ovr = 0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer pops the oldest expected byte; pulses are counted.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ferr = 1'b0;
      prev_ovr  = 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        model_full = 1'b0;
      end
      if (frame_err) begin
        obs_ferr++;
        check("frame_err_width", {31'd0, prev_ferr}, 32'd0);
      end
      if (overrun) begin
        obs_ovr++;
        check("overrun_width", {31'd0, prev_ovr}, 32'd0);
      end
      prev_ferr = frame_err;
      prev_ovr  = overrun;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // stop_low > 0 holds the stop bit low for that many bit periods.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_low > 0) begin
      exp_ferr++;
      rx = 1'b0;
      repeat (stop_low * CPB) @(posedge clk);
      #1;
      drive_bit(1'b1);
    end else begin
      if (model_full && !rx_ready) begin
        exp_ovr++;
      end else begin
        exp_q.push_back(b);
        model_full = 1'b1;
      end
      drive_bit(1'b1);
    end
  endtask

  task automatic glitch(input int n);
    rx = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    idle(2 * CPB);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ferr_count"}, obs_ferr, exp_ferr);
    check({tag, "_ovr_count"}, obs_ovr, exp_ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int         wait_cnt;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(4);

    // Single byte with consumer stalled, then a one-cycle accept.
    send_frame(8'hA5, 0);
    check("single_valid", {31'd0, rx_valid}, 32'd1);
    check("single_data", {24'd0, rx_data}, 32'hA5);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("single_valid_clear", {31'd0, rx_valid}, 32'd0);
    idle(4);

    // Glitch shorter than half a bit.
    glitch(3);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check_counts("glitch");

    // Framing error, then recovery.
    send_frame(8'h3C, 2);
    check("ferr_valid", {31'd0, rx_valid}, 32'd0);
    check_counts("ferr");
    rx_ready = 1'b1;
    send_frame(8'h5A, 0);
    idle(4);
    rx_ready = 1'b0;

    // Overrun: second byte dropped, first retained.
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    check("ovr_data_held", {24'd0, rx_data}, 32'h11);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check_counts("ovr");
    rx_ready = 1'b1;
    idle(4);

    // Streaming back-to-back with consumer always ready.
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    send_frame(8'h81, 0);
    idle(4);
    check_counts("stream");

    // Reset in the middle of data bit 4.
    pat = 8'hC3;
    rx_ready = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pat[i]);
    rx = pat[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx = 1'b1;
    model_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    idle(4);
    rx_ready = 1'b1;
    send_frame(8'h7E, 0);
    idle(4);

    // Randomized frames, glitches, errors and consumer stalls.
    for (int k = 0; k < 30; k++) begin
      int act;
      act = $urandom_range(0, 9);
      idle($urandom_range(0, 10));
      if (act == 0) begin
        glitch($urandom_range(1, 3));
      end else begin
        rx_ready = ($urandom_range(0, 3) != 0);
        send_frame(8'($urandom_range(0, 255)), (act == 1) ? $urandom_range(1, 2) : 0);
      end
    end

    rx_ready = 1'b1;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_valid", {31'd0, rx_valid}, 32'd0);
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
